// File: rtl/pcileech_eth_pkg.sv
// Shared definitions for the RMII Ethernet datapath: framer states, frame constants and
// the bit-serial CRC-32 step used by both the TX framer and the RX FCS checker.
package pcileech_eth_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StPreamble = 3'd1;
  localparam state_t StData     = 3'd2;
  localparam state_t StPad      = 3'd3;
  localparam state_t StFcs      = 3'd4;
  localparam state_t StIpg      = 3'd5;

  localparam int unsigned ETH_PREAMBLE_DIBITS = 32;
  localparam int unsigned ETH_FCS_DIBITS      = 16;
  localparam logic [31:0] ETH_CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT        = 32'hFFFFFFFF;

  // One reflected CRC-32 step for a single wire bit.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
    return (crc[0] ^ b) ? ((crc >> 1) ^ ETH_CRC_POLY) : (crc >> 1);
  endfunction

endpackage

// File: rtl/pcileech_eth_rmii_tx_if.sv
// Byte-stream handshake between the frame builder and the RMII TX framer.
interface pcileech_eth_rmii_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/pcileech_eth_crc32_d2.sv
// Combinational CRC-32 update for one RMII dibit (bit0 is the first bit on the wire).
module pcileech_eth_crc32_d2
  import pcileech_eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);
  logic [31:0] crc_mid;

  assign crc_mid = crc32_bit(crc_in, dibit[0]);
  assign crc_out = crc32_bit(crc_mid, dibit[1]);
endmodule

// File: rtl/pcileech_eth_rmii_tx.sv
// RMII transmit framer: preamble/SFD, byte serialisation, zero padding, FCS and
// inter-packet gap, one dibit per 50 MHz cycle.
module pcileech_eth_rmii_tx
  import pcileech_eth_pkg::*;
#(
  parameter int unsigned PARAM_MIN_FRAME_BYTES = 60,
  parameter int unsigned PARAM_IPG_BYTES       = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pcileech_eth_rmii_tx_if.slave  s,
  output logic                   eth_tx_en,
  output logic [1:0]             eth_tx_data,
  output logic                   busy,
  output logic                   underrun,
  output logic [15:0]            frame_count
);

  // The cycle spent in IDLE before the next preamble completes the gap.
  localparam int unsigned IpgCycles = (PARAM_IPG_BYTES * 4 > 1) ? PARAM_IPG_BYTES * 4 - 1 : 1;
  localparam logic [12:0] IpgLast   = 13'(IpgCycles - 1);

  state_t      state_q, state_d;
  logic [1:0]  dibit_q, dibit_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  tx_data_q, tx_data_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_count_q;
  logic        frame_done;
  logic        ready;
  logic [10:0] cnt_inc;
  logic [31:0] cnt_plus1;
  logic [1:0]  crc_dibit;
  logic        pre_last;
  logic        fcs_last;

  assign cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign cnt_plus1 = {21'd0, cnt_q} + 32'd1;
  assign pre_last  = ({cnt_q[2:0], dibit_q} == 5'(ETH_PREAMBLE_DIBITS - 1));
  assign fcs_last  = ({cnt_q[1:0], dibit_q} == 4'(ETH_FCS_DIBITS - 1));
  assign crc_dibit = (state_q == StData) ? shift_q[1:0] : 2'b00;

  pcileech_eth_crc32_d2 u_crc (
    .crc_in  (crc_q),
    .dibit   (crc_dibit),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d    = state_q;
    dibit_d    = dibit_q + 2'd1;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    crc_d      = crc_q;
    tx_en_d    = 1'b0;
    tx_data_d  = 2'b00;
    underrun_d = 1'b0;
    frame_done = 1'b0;
    ready      = 1'b0;
    unique case (state_q)
      StIdle: begin
        dibit_d = 2'd0;
        cnt_d   = 11'd0;
        crc_d   = ETH_CRC_INIT;
        if (s.s_valid) state_d = StPreamble;
      end
      StPreamble: begin
        tx_en_d   = 1'b1;
        tx_data_d = 2'b01;
        if (pre_last) begin
          ready   = 1'b1;
          dibit_d = 2'd0;
          cnt_d   = 11'd0;
          if (s.s_valid) begin
            tx_data_d = 2'b11;
            shift_d   = s.s_data;
            last_d    = s.s_last;
            state_d   = StData;
          end else begin
            tx_en_d    = 1'b0;
            underrun_d = 1'b1;
            state_d    = StIpg;
          end
        end else if (dibit_q == 2'd3) begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StData: begin
        tx_en_d   = 1'b1;
        tx_data_d = shift_q[1:0];
        shift_d   = {2'b00, shift_q[7:2]};
        crc_d     = crc_next;
        if (dibit_q == 2'd3) begin
          if (last_q) begin
            if (cnt_plus1 < PARAM_MIN_FRAME_BYTES) begin
              cnt_d   = cnt_inc;
              state_d = StPad;
            end else begin
              cnt_d   = 11'd0;
              state_d = StFcs;
            end
          end else begin
            ready = 1'b1;
            if (s.s_valid) begin
              shift_d = s.s_data;
              last_d  = s.s_last;
              cnt_d   = cnt_inc;
            end else begin
              underrun_d = 1'b1;
              cnt_d      = 11'd0;
              state_d    = StIpg;
            end
          end
        end
      end
      StPad: begin
        tx_en_d = 1'b1;
        crc_d   = crc_next;
        if (dibit_q == 2'd3) begin
          if (cnt_plus1 >= PARAM_MIN_FRAME_BYTES) begin
            cnt_d   = 11'd0;
            state_d = StFcs;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StFcs: begin
        tx_en_d   = 1'b1;
        tx_data_d = ~crc_q[1:0];
        crc_d     = {2'b00, crc_q[31:2]};
        if (fcs_last) begin
          crc_d      = ETH_CRC_INIT;
          cnt_d      = 11'd0;
          frame_done = 1'b1;
          state_d    = StIpg;
        end else if (dibit_q == 2'd3) begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      StIpg: begin
        crc_d = ETH_CRC_INIT;
        if ({cnt_q, dibit_q} == IpgLast) begin
          state_d = StIdle;
        end else if (dibit_q == 2'd3) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      dibit_q       <= 2'd0;
      cnt_q         <= 11'd0;
      shift_q       <= 8'd0;
      last_q        <= 1'b0;
      crc_q         <= ETH_CRC_INIT;
      tx_en_q       <= 1'b0;
      tx_data_q     <= 2'b00;
      underrun_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      dibit_q    <= dibit_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      underrun_q <= underrun_d;
      if (frame_done) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign s.s_ready   = ready;
  assign eth_tx_en   = tx_en_q;
  assign eth_tx_data = tx_data_q;
  assign busy        = (state_q != StIdle);
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pcileech_eth_rmii_tx.sv
// Self-checking bench for the RMII TX framer: scoreboard of expected wire bytes per frame.
module tb_pcileech_eth_rmii_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  pcileech_eth_rmii_tx_if bus ();
  pcileech_eth_rmii_tx_if bus0 ();

  logic [7:0] drv_data = 8'd0;
  logic drv_valid = 1'b0, drv_last = 1'b0, sel = 1'b0, abort = 1'b0;
  logic rdy;

  assign bus.s_data   = drv_data;
  assign bus.s_last   = drv_last;
  assign bus.s_valid  = drv_valid & ~sel;
  assign bus0.s_data  = drv_data;
  assign bus0.s_last  = drv_last;
  assign bus0.s_valid = drv_valid & sel;
  assign rdy = sel ? bus0.s_ready : bus.s_ready;

  logic        eth_tx_en, busy, underrun;
  logic [1:0]  eth_tx_data;
  logic [15:0] frame_count;
  logic        tx_en0, busy0, underrun0;
  logic [1:0]  tx_data0;
  logic [15:0] fc0;

  pcileech_eth_rmii_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (bus.slave),
    .eth_tx_en   (eth_tx_en),
    .eth_tx_data (eth_tx_data),
    .busy        (busy),
    .underrun    (underrun),
    .frame_count (frame_count)
  );

  pcileech_eth_rmii_tx #(.PARAM_MIN_FRAME_BYTES(0), .PARAM_IPG_BYTES(12)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (bus0.slave),
    .eth_tx_en   (tx_en0),
    .eth_tx_data (tx_data0),
    .busy        (busy0),
    .underrun    (underrun0),
    .frame_count (fc0)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_buf [2048];
  logic [7:0] exp_bytes [$];
  int         exp_lens [$];
  logic [7:0] rx0 [$];

  // Reference CRC: classic byte-wise reflected CRC-32, result already complemented.
  function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'd0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Monitor / scoreboard for the main DUT.
  int         mon_dcnt = 0, last_len = 0, gap_cnt = 0, last_gap = 0;
  int         ur_pulses = 0;
  logic       mon_en_prev = 1'b0, ur_prev = 1'b0, ur_en_at = 1'b0, ur_next_en = 1'b1;
  logic [63:0] pre;
  logic [7:0]  acc, first_dib, exp_b;
  int          exp_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_dcnt    = 0;
      mon_en_prev = 1'b0;
      gap_cnt     = 0;
      ur_prev     = 1'b0;
    end else begin
      if (ur_prev) ur_next_en = eth_tx_en;
      if (underrun) begin
        ur_pulses++;
        ur_en_at = eth_tx_en;
      end
      ur_prev = underrun;
      if (eth_tx_en) begin
        if (!mon_en_prev) begin
          last_gap = gap_cnt;
          gap_cnt  = 0;
          mon_dcnt = 0;
        end
        if (mon_dcnt < 32) begin
          pre[2*mon_dcnt +: 2] = eth_tx_data;
          if (mon_dcnt == 31) begin
            checks++;
            if (pre !== 64'hD555_5555_5555_5555) begin
              errors++;
              $display("FAIL preamble got %h exp d555555555555555", pre);
            end
          end
        end else begin
          if (mon_dcnt < 36) first_dib = {first_dib[5:0], eth_tx_data};
          acc[2*((mon_dcnt - 32) % 4) +: 2] = eth_tx_data;
          if ((mon_dcnt - 32) % 4 == 3) begin
            checks++;
            if (exp_bytes.size() == 0) begin
              errors++;
              $display("FAIL sb_byte got %h exp none", acc);
            end else begin
              exp_b = exp_bytes.pop_front();
              if (acc !== exp_b) begin
                errors++;
                $display("FAIL sb_byte got %h exp %h", acc, exp_b);
              end
            end
          end
        end
        mon_dcnt++;
      end else begin
        if (mon_en_prev) begin
          last_len = mon_dcnt;
          checks++;
          if (exp_lens.size() == 0) begin
            errors++;
            $display("FAIL sb_frame got %0d dibits exp no frame", mon_dcnt);
          end else begin
            exp_l = exp_lens.pop_front();
            if (mon_dcnt !== 32 + 4 * exp_l) begin
              errors++;
              $display("FAIL sb_frame_len got %0d dibits exp %0d", mon_dcnt, 32 + 4 * exp_l);
            end
          end
        end
        gap_cnt++;
      end
      mon_en_prev = eth_tx_en;
    end
  end

  // Byte capture for the unpadded instance.
  int         d0cnt = 0;
  logic [7:0] acc0;
  always @(negedge clk) begin
    if (!rst_n || !tx_en0) begin
      d0cnt = 0;
    end else begin
      if (d0cnt >= 32) begin
        acc0[2*((d0cnt - 32) % 4) +: 2] = tx_data0;
        if ((d0cnt - 32) % 4 == 3) rx0.push_back(acc0);
      end
      d0cnt++;
    end
  end

  task automatic push_frame(input int n);
    logic [7:0]  fr[$];
    logic [31:0] f;
    for (int i = 0; i < n; i++) fr.push_back(tx_buf[i]);
    while (fr.size() < 60) fr.push_back(8'h00);
    f = crc_ref(fr);
    for (int k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
    foreach (fr[j]) exp_bytes.push_back(fr[j]);
    exp_lens.push_back(fr.size());
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
  endtask

  task automatic drive_frame(input int n, input int stop_at, input bit hold, input bit stall);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) begin
        drv_valid = 1'b0;
        return;
      end
      drv_data  = tx_buf[i];
      drv_last  = (i == n - 1);
      drv_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (abort) begin
          drv_valid = 1'b0;
          return;
        end
        if (rdy) break;
        if (stall) drv_data = 8'($urandom);
        t++;
        if (t > 2000) begin
          checks++;
          errors++;
          $display("FAIL handshake byte %0d got timeout exp s_ready", i);
          drv_valid = 1'b0;
          return;
        end
      end
      drv_data = tx_buf[i];
      @(posedge clk);
      #1;
    end
    if (!hold) drv_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit use0);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((use0 ? busy0 : busy) && t < 5000);
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got busy exp idle within 5000 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (eth_tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en got %b exp 0", eth_tx_en); end
    if (eth_tx_data !== 2'b00) begin errors++; $display("FAIL rst_tx_data got %b exp 00", eth_tx_data); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_fc got %0d exp 0", frame_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", bus.s_ready); end
    if (eth_tx_en !== 1'b0) begin errors++; $display("FAIL idle_tx_en got %b exp 0", eth_tx_en); end
  endtask

  task automatic test_preamble();
    tx_buf[0] = 8'hAB;
    push_frame(1);
    drive_frame(1, -1, 1'b0, 1'b0);
    wait_idle(1'b0);
    checks += 4;
    if (first_dib !== 8'b11_10_10_10) begin errors++; $display("FAIL first_dibits got %b exp 11101010", first_dib); end
    if (last_len !== 288) begin errors++; $display("FAIL tx_en_len got %0d exp 288", last_len); end
    if (frame_count !== 16'd1) begin errors++; $display("FAIL pre_fc got %0d exp 1", frame_count); end
    if (exp_bytes.size() !== 0) begin errors++; $display("FAIL pre_sb_left got %0d exp 0", exp_bytes.size()); end
  endtask

  task automatic test_fcs();
    logic [7:0] fcs_exp [4];
    fcs_exp[0] = 8'h26; fcs_exp[1] = 8'h39; fcs_exp[2] = 8'hF4; fcs_exp[3] = 8'hCB;
    rx0.delete();
    for (int i = 0; i < 9; i++) tx_buf[i] = 8'h31 + 8'(i);
    sel = 1'b1;
    drive_frame(9, -1, 1'b0, 1'b0);
    wait_idle(1'b1);
    sel = 1'b0;
    checks += 2;
    if (rx0.size() !== 13) begin errors++; $display("FAIL fcs_len got %0d exp 13", rx0.size()); end
    if (fc0 !== 16'd1) begin errors++; $display("FAIL fcs_fc got %0d exp 1", fc0); end
    if (rx0.size() == 13) begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx0[i] !== 8'h31 + 8'(i)) begin
          errors++;
          $display("FAIL fcs_data[%0d] got %h exp %h", i, rx0[i], 8'h31 + 8'(i));
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rx0[9+k] !== fcs_exp[k]) begin
          errors++;
          $display("FAIL fcs_byte[%0d] got %h exp %h", k, rx0[9+k], fcs_exp[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(64);
    push_frame(64);
    drive_frame(64, -1, 1'b1, 1'b0);
    fill_random(64);
    push_frame(64);
    drive_frame(64, -1, 1'b0, 1'b0);
    wait_idle(1'b0);
    checks += 4;
    if (last_gap !== 48) begin errors++; $display("FAIL b2b_gap got %0d exp 48", last_gap); end
    if (last_len !== 304) begin errors++; $display("FAIL b2b_len got %0d exp 304", last_len); end
    if (frame_count !== 16'd3) begin errors++; $display("FAIL b2b_fc got %0d exp 3", frame_count); end
    if (exp_bytes.size() !== 0) begin errors++; $display("FAIL b2b_sb_left got %0d exp 0", exp_bytes.size()); end
  endtask

  task automatic test_underrun();
    ur_pulses = 0;
    fill_random(20);
    for (int i = 0; i < 10; i++) exp_bytes.push_back(tx_buf[i]);
    exp_lens.push_back(10);
    drive_frame(20, 10, 1'b0, 1'b0);
    wait_idle(1'b0);
    checks += 5;
    if (ur_pulses !== 1) begin errors++; $display("FAIL ur_pulses got %0d exp 1", ur_pulses); end
    if (ur_en_at !== 1'b1) begin errors++; $display("FAIL ur_en_at got %b exp 1", ur_en_at); end
    if (ur_next_en !== 1'b0) begin errors++; $display("FAIL ur_next_en got %b exp 0", ur_next_en); end
    if (frame_count !== 16'd3) begin errors++; $display("FAIL ur_fc got %0d exp 3", frame_count); end
    if (exp_bytes.size() !== 0) begin errors++; $display("FAIL ur_sb_left got %0d exp 0", exp_bytes.size()); end
    fill_random(20);
    push_frame(20);
    drive_frame(20, -1, 1'b0, 1'b0);
    wait_idle(1'b0);
    checks += 3;
    if (frame_count !== 16'd4) begin errors++; $display("FAIL ur_next_fc got %0d exp 4", frame_count); end
    if (last_len !== 288) begin errors++; $display("FAIL ur_next_len got %0d exp 288", last_len); end
    if (ur_pulses !== 1) begin errors++; $display("FAIL ur_extra got %0d exp 1", ur_pulses); end
  endtask

  task automatic test_reset_mid();
    fill_random(40);
    push_frame(40);
    fork
      drive_frame(40, -1, 1'b0, 1'b0);
    join_none
    repeat (80) @(posedge clk);
    #3;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (eth_tx_en !== 1'b0) begin errors++; $display("FAIL rm_tx_en got %b exp 0", eth_tx_en); end
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rm_fc got %0d exp 0", frame_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    exp_bytes.delete();
    exp_lens.delete();
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_random(60);
    push_frame(60);
    drive_frame(60, -1, 1'b0, 1'b0);
    wait_idle(1'b0);
    checks += 3;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL rm_post_fc got %0d exp 1", frame_count); end
    if (last_len !== 288) begin errors++; $display("FAIL rm_post_len got %0d exp 288", last_len); end
    if (exp_bytes.size() !== 0) begin errors++; $display("FAIL rm_sb_left got %0d exp 0", exp_bytes.size()); end
  endtask

  task automatic test_stall();
    fill_random(30);
    push_frame(30);
    drive_frame(30, -1, 1'b0, 1'b1);
    wait_idle(1'b0);
    checks += 3;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL stall_fc got %0d exp 2", frame_count); end
    if (last_len !== 288) begin errors++; $display("FAIL stall_len got %0d exp 288", last_len); end
    if (exp_bytes.size() !== 0) begin errors++; $display("FAIL stall_sb_left got %0d exp 0", exp_bytes.size()); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preamble();
    test_fcs();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcileech_eth_rmii_tx.md
Name: pcileech_eth_rmii_tx

Overview:
RMII transmit framer for the Ethernet communication path. It takes a byte stream of a complete Ethernet frame (destination MAC through payload) and serialises it onto RMII dibits. It adds the preamble and SFD, pads the frame to minimum length, appends the CRC-32 FCS and enforces the inter-packet gap. It sits between the UDP/ARP frame builder of the ETH com stack and the board's eth_tx_en/eth_tx_data pins, and is the counterpart of the RMII receive path.

Parameters:
PARAM_MIN_FRAME_BYTES, 60, minimum data+pad byte count before FCS; 0 disables padding.
PARAM_IPG_BYTES, 12, inter-packet gap in byte times (4 cycles each).

Ports:
clk  in  1  50 MHz RMII reference clock, one dibit per cycle.
rst_n  in  1  asynchronous active-low reset.
s_data  in  8  frame byte.
s_valid  in  1  s_data valid.
s_last  in  1  s_data is the final frame byte.
s_ready  out  1  byte accepted when s_valid && s_ready.
eth_tx_en  out  1  RMII TX_EN (registered).
eth_tx_data  out  2  RMII TXD, bit0 = first bit on wire (registered).
busy  out  1  state != IDLE.
underrun  out  1  one-cycle pulse on mid-frame starvation.
frame_count  out  16  frames completed with FCS, wraps at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - eth_tx_en=0, eth_tx_data=0, underrun=0, frame_count=0.
  - State IDLE, CRC=0xFFFFFFFF.
  - A reset mid-frame drops tx_en immediately. No FCS is sent and the frame is not counted.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IPG. A 2-bit dibit index and an 11-bit byte counter (saturates at 2047) run alongside.
- IDLE:
  - s_ready=0.
  - On s_valid=1, go to PREAMBLE next cycle, with the dibit counter at 0.
  - No byte is consumed in IDLE.
- PREAMBLE:
  - Runs 32 cycles, tx_en=1.
  - Dibits 0..30 are 2'b01. Dibit 31 is 2'b11 (SFD 0xD5, LSB first).
  - s_ready=1 only on the cycle of dibit 31. The byte is loaded on that handshake and DATA starts next cycle.
  - If s_valid=0 at dibit 31: assert underrun, go to IPG, drop tx_en.
- DATA:
  - The loaded byte is shifted out LSB dibit first (bits[1:0], [3:2], [5:4], [7:6]). One byte takes 4 cycles.
  - Each dibit updates the CRC.
  - At dibit index 3:
    - If the current byte is s_last: s_ready=0. Next state is PAD if byte_count+1 < PARAM_MIN_FRAME_BYTES, otherwise FCS.
    - Otherwise s_ready=1. If s_valid, load the next byte and stay in DATA (no gap between bytes).
    - Otherwise assert underrun for one pulse, tx_en=0 next cycle, go to IPG. No FCS is sent.
- PAD:
  - Sends 0x00 bytes; the CRC includes them.
  - Leaves for FCS at the dibit-3 boundary once byte_count reaches PARAM_MIN_FRAME_BYTES.
- FCS:
  - Runs 16 cycles. The value sent is ~CRC, LSB first, 2 bits per cycle (wire byte order is FCS[7:0] first).
  - After the 16th dibit: frame_count++, CRC reloads to 0xFFFFFFFF, go to IPG.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, two bit-serial steps per cycle (bit0, then bit1).
- IPG:
  - tx_en=0, eth_tx_data=0 for PARAM_IPG_BYTES*4 cycles, then IDLE.
  - s_valid is ignored in IPG. Back-to-back frames therefore have exactly 48 idle cycles between the last FCS dibit and the first preamble dibit at defaults.
- Output timing: eth_tx_en/eth_tx_data are registered one cycle after the state/dibit decision. Latency from s_valid rising in IDLE to the first tx_en cycle is 2 cycles.
- s_data is sampled only on the handshake. Changes while s_ready=0 have no effect.

Decomposition:
- Shared package pcileech_eth_pkg:
  - State enum.
  - Constants: ETH_PREAMBLE_DIBITS=32, ETH_FCS_DIBITS=16, ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF.
- Sub-module pcileech_eth_crc32_d2: combinational CRC step (crc_in[31:0], dibit[1:0] -> crc_out[31:0]). It is reused by the RX FCS checker.

Test Plan:
- Preamble/SFD: 1-byte frame 0xAB, defaults.
  - First 32 tx_en cycles are 31x 01 then 11.
  - Next 4 dibits are 11,10,10,10.
  - Total tx_en high for 32+240+16 = 288 cycles.
  - frame_count=1.
- FCS check: PARAM_MIN_FRAME_BYTES=0, frame "123456789" (0x31..0x39).
  - FCS bytes on wire are 0x26,0x39,0xF4,0xCB (CRC 0xCBF43926).
- Back-to-back: two 64-byte frames with s_valid held high.
  - Exactly 48 cycles of tx_en=0 between frames; no byte gaps inside a frame.
  - frame_count=2.
- Underrun: drop s_valid at byte 10 of a 20-byte frame.
  - underrun pulses once, tx_en falls the next cycle, no FCS is sent.
  - frame_count unchanged; the next frame is sent correctly after the IPG.
- Reset mid-frame: assert rst_n=0 during DATA.
  - tx_en=0 asynchronously, frame_count=0.
  - After release, a 60-byte frame transmits with correct FCS.
- Stall tolerance: s_data toggles randomly while s_ready=0.
  - The transmitted bytes match only the handshaken bytes.
